// File: rtl/regfile_wb_arbiter.sv
// Write-side front end of the register file: merges ALU and long-latency writebacks
// onto one registered write port, with forwarding, pending mask and drained status.
module regfile_wb_arbiter #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned NREGS = 32
) (
    input  logic                     clk,
    input  logic                     rst_b,
    input  logic                     alu_valid_i,
    input  logic [$clog2(NREGS)-1:0] alu_num_i,
    input  logic [XLEN-1:0]          alu_data_i,
    input  logic                     lsu_valid_i,
    output logic                     lsu_ready_o,
    input  logic [$clog2(NREGS)-1:0] lsu_num_i,
    input  logic [XLEN-1:0]          lsu_data_i,
    output logic [$clog2(NREGS)-1:0] rd_num_o,
    output logic [XLEN-1:0]          rd_data_o,
    output logic                     rd_we_o,
    input  logic [$clog2(NREGS)-1:0] rs_num_i,
    input  logic [$clog2(NREGS)-1:0] rt_num_i,
    output logic                     rs_fwd_valid_o,
    output logic [XLEN-1:0]          rs_fwd_data_o,
    output logic                     rt_fwd_valid_o,
    output logic [XLEN-1:0]          rt_fwd_data_o,
    output logic [NREGS-1:0]         pending_mask_o,
    output logic                     drained_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned RW = $clog2(NREGS);
    localparam int unsigned CW = PW + 1;

    logic [RW-1:0]   num_q  [DEPTH];
    logic [XLEN-1:0] data_q [DEPTH];
    logic [DEPTH-1:0] live_q, live_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;

    logic            rd_we_q, rd_we_d;
    logic [RW-1:0]   rd_num_q, rd_num_d;
    logic [XLEN-1:0] rd_data_q, rd_data_d;

    logic alu_wr, full, push, pop;

    assign alu_wr = alu_valid_i && (alu_num_i != '0);
    assign full   = (count_q == CW'(DEPTH));
    // Enqueue sees only the registered full flag; a same-cycle pop does not make room.
    assign push   = lsu_valid_i && !full && (lsu_num_i != '0);
    assign pop    = !alu_wr && (count_q != '0);

    always_comb begin
        live_d   = live_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // An accepted ALU write supersedes every older buffered write to the same register.
        if (alu_wr) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (num_q[i] == alu_num_i) begin
                    live_d[i] = 1'b0;
                end
            end
        end
        if (pop) begin
            live_d[rd_ptr_q] = 1'b0;
            rd_ptr_d         = rd_ptr_q + 1'b1;
        end
        if (push) begin
            live_d[wr_ptr_q] = 1'b1;
            wr_ptr_d         = wr_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        rd_we_d   = 1'b0;
        rd_num_d  = rd_num_q;
        rd_data_d = rd_data_q;
        if (alu_wr) begin
            rd_we_d   = 1'b1;
            rd_num_d  = alu_num_i;
            rd_data_d = alu_data_i;
        end else if (pop) begin
            rd_we_d   = live_q[rd_ptr_q];
            rd_num_d  = num_q[rd_ptr_q];
            rd_data_d = data_q[rd_ptr_q];
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            live_q    <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rd_we_q   <= 1'b0;
            rd_num_q  <= '0;
            rd_data_q <= '0;
        end else begin
            live_q    <= live_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            rd_we_q   <= rd_we_d;
            rd_num_q  <= rd_num_d;
            rd_data_q <= rd_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            num_q[wr_ptr_q]  <= lsu_num_i;
            data_q[wr_ptr_q] <= lsu_data_i;
        end
    end

    // Scan oldest to youngest so the youngest live match wins; live implies occupied.
    function automatic logic [XLEN:0] fwd_lookup(input logic [RW-1:0] idx_num);
        logic [PW-1:0] idx;
        logic          hit;
        logic [XLEN-1:0] val;
        hit = rd_we_q && (rd_num_q == idx_num);
        val = rd_data_q;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr_q + PW'(k);
            if (live_q[idx] && (num_q[idx] == idx_num)) begin
                hit = 1'b1;
                val = data_q[idx];
            end
        end
        if (idx_num == '0) begin
            hit = 1'b0;
        end
        return {hit, val};
    endfunction

    always_comb begin
        {rs_fwd_valid_o, rs_fwd_data_o} = fwd_lookup(rs_num_i);
        {rt_fwd_valid_o, rt_fwd_data_o} = fwd_lookup(rt_num_i);
    end

    always_comb begin
        pending_mask_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live_q[i]) begin
                pending_mask_o[num_q[i]] = 1'b1;
            end
        end
        if (rd_we_q) begin
            pending_mask_o[rd_num_q] = 1'b1;
        end
        pending_mask_o[0] = 1'b0;
    end

    assign lsu_ready_o = !full;
    assign rd_we_o     = rd_we_q;
    assign rd_num_o    = rd_num_q;
    assign rd_data_o   = rd_data_q;
    assign drained_o   = (count_q == '0) && !rd_we_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter; expected writes are queued when stimulus is
// driven and checked by a monitor whenever the write port fires.
module tb_regfile_wb_arbiter;

    logic        clk;
    logic        rst_b;
    logic        alu_valid;
    logic [4:0]  alu_num;
    logic [31:0] alu_data;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [4:0]  lsu_num;
    logic [31:0] lsu_data;
    logic [4:0]  rd_num;
    logic [31:0] rd_data;
    logic        rd_we;
    logic [4:0]  rs_num;
    logic [4:0]  rt_num;
    logic        rs_fwd_valid;
    logic [31:0] rs_fwd_data;
    logic        rt_fwd_valid;
    logic [31:0] rt_fwd_data;
    logic [31:0] pending_mask;
    logic        drained;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [4:0]  num;
        logic [31:0] data;
    } wr_t;
    wr_t sb[$];

    regfile_wb_arbiter #(
        .XLEN  (32),
        .DEPTH (4),
        .NREGS (32)
    ) dut (
        .clk            (clk),
        .rst_b          (rst_b),
        .alu_valid_i    (alu_valid),
        .alu_num_i      (alu_num),
        .alu_data_i     (alu_data),
        .lsu_valid_i    (lsu_valid),
        .lsu_ready_o    (lsu_ready),
        .lsu_num_i      (lsu_num),
        .lsu_data_i     (lsu_data),
        .rd_num_o       (rd_num),
        .rd_data_o      (rd_data),
        .rd_we_o        (rd_we),
        .rs_num_i       (rs_num),
        .rt_num_i       (rt_num),
        .rs_fwd_valid_o (rs_fwd_valid),
        .rs_fwd_data_o  (rs_fwd_data),
        .rt_fwd_valid_o (rt_fwd_valid),
        .rt_fwd_data_o  (rt_fwd_data),
        .pending_mask_o (pending_mask),
        .drained_o      (drained)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic exp_wr(input logic [4:0] n, input logic [31:0] d);
        sb.push_back({n, d});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Every real write must match the head of the expected-write queue.
    always @(posedge clk) begin
        wr_t e;
        #1;
        if (rst_b === 1'b1 && rd_we === 1'b1) begin
            chk("rd_num_nonzero", 32'(rd_num != 5'd0), 32'd1);
            chk("sb_has_entry", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("sb_rd_num", 32'(rd_num), 32'(e.num));
                chk("sb_rd_data", rd_data, e.data);
            end
        end
    end

    initial begin
        int n;
        rst_b     = 1'b0;
        alu_valid = 1'b0;
        alu_num   = '0;
        alu_data  = '0;
        lsu_valid = 1'b0;
        lsu_num   = '0;
        lsu_data  = '0;
        rs_num    = 5'd5;
        rt_num    = 5'd0;
        #2;
        chk("rst_rd_we", 32'(rd_we), 32'd0);
        chk("rst_rd_num", 32'(rd_num), 32'd0);
        chk("rst_rd_data", rd_data, 32'd0);
        chk("rst_lsu_ready", 32'(lsu_ready), 32'd1);
        chk("rst_pending", pending_mask, 32'd0);
        chk("rst_drained", 32'(drained), 32'd1);
        chk("rst_fwd_valid", 32'(rs_fwd_valid), 32'd0);
        step();
        step();
        rst_b = 1'b1;

        // Single ALU write, one-cycle latency
        alu_valid = 1'b1; alu_num = 5'd5; alu_data = 32'hAAAA5555;
        exp_wr(5'd5, 32'hAAAA5555);
        step();
        alu_valid = 1'b0;
        #1;
        chk("t1_rd_we", 32'(rd_we), 32'd1);
        chk("t1_rd_num", 32'(rd_num), 32'd5);
        chk("t1_rd_data", rd_data, 32'hAAAA5555);
        chk("t1_drained", 32'(drained), 32'd0);
        chk("t1_pending", pending_mask, 32'h0000_0020);
        chk("t1_rs_fwd_valid", 32'(rs_fwd_valid), 32'd1);
        chk("t1_rs_fwd_data", rs_fwd_data, 32'hAAAA5555);
        step();
        chk("t1_rd_we_off", 32'(rd_we), 32'd0);
        chk("t1_drained_back", 32'(drained), 32'd1);

        // Fill the FIFO while the ALU owns the port, then drain in order
        for (int k = 0; k < 4; k++) begin
            alu_valid = 1'b1; alu_num = 5'(20 + k); alu_data = 32'h200 + 32'(k);
            lsu_valid = 1'b1; lsu_num = 5'(k + 1); lsu_data = 32'h11 * 32'(k + 1);
            exp_wr(5'(20 + k), 32'h200 + 32'(k));
            step();
        end
        chk("t2_full_ready", 32'(lsu_ready), 32'd0);
        alu_num = 5'd24; alu_data = 32'h224;
        lsu_num = 5'd6;  lsu_data = 32'h66;
        exp_wr(5'd24, 32'h224);
        step();
        alu_valid = 1'b0; lsu_valid = 1'b0;
        rs_num = 5'd3; rt_num = 5'd24;
        #1;
        chk("t2_still_full", 32'(lsu_ready), 32'd0);
        chk("t2_pending", pending_mask, 32'h0100_001E);
        chk("t2_rs_fwd_valid", 32'(rs_fwd_valid), 32'd1);
        chk("t2_rs_fwd_data", rs_fwd_data, 32'h33);
        chk("t2_rt_fwd_data", rt_fwd_data, 32'h224);
        for (int k = 0; k < 4; k++) begin
            exp_wr(5'(k + 1), 32'h11 * 32'(k + 1));
        end
        for (int k = 0; k < 4; k++) begin
            step();
            chk("t2_pop_we", 32'(rd_we), 32'd1);
            chk("t2_pop_num", 32'(rd_num), 32'(k + 1));
            if (k == 0) chk("t2_ready_after_pop", 32'(lsu_ready), 32'd1);
        end
        step();
        chk("t2_idle_we", 32'(rd_we), 32'd0);

        // ALU write kills an older buffered write to the same register
        alu_valid = 1'b1; alu_num = 5'd10; alu_data = 32'hA0;
        lsu_valid = 1'b1; lsu_num = 5'd7;  lsu_data = 32'h70;
        exp_wr(5'd10, 32'hA0);
        step();
        lsu_valid = 1'b0;
        alu_num = 5'd7; alu_data = 32'h71;
        rt_num = 5'd7;
        #1;
        chk("t3_fwd_before_kill", rt_fwd_data, 32'h70);
        exp_wr(5'd7, 32'h71);
        step();
        alu_valid = 1'b0;
        #1;
        chk("t3_rd_num", 32'(rd_num), 32'd7);
        chk("t3_rd_data", rd_data, 32'h71);
        chk("t3_rt_fwd_valid", 32'(rt_fwd_valid), 32'd1);
        chk("t3_rt_fwd_data", rt_fwd_data, 32'h71);
        chk("t3_pending", pending_mask, 32'h0000_0080);
        step();
        chk("t3_dead_pop_we", 32'(rd_we), 32'd0);
        chk("t3_rt_fwd_gone", 32'(rt_fwd_valid), 32'd0);
        chk("t3_drained", 32'(drained), 32'd1);
        chk("t3_pending_clr", pending_mask, 32'd0);

        // Same-cycle ALU and LSU to r9: LSU is younger
        alu_valid = 1'b1; alu_num = 5'd9; alu_data = 32'h90;
        lsu_valid = 1'b1; lsu_num = 5'd9; lsu_data = 32'h91;
        exp_wr(5'd9, 32'h90);
        exp_wr(5'd9, 32'h91);
        step();
        alu_valid = 1'b0; lsu_valid = 1'b0;
        rs_num = 5'd9;
        #1;
        chk("t4_rd_data_first", rd_data, 32'h90);
        chk("t4_rs_fwd_valid", 32'(rs_fwd_valid), 32'd1);
        chk("t4_rs_fwd_data", rs_fwd_data, 32'h91);
        step();
        chk("t4_rd_data_second", rd_data, 32'h91);
        chk("t4_rs_fwd_data2", rs_fwd_data, 32'h91);
        step();
        chk("t4_idle_we", 32'(rd_we), 32'd0);

        // Writes to r0 from both paths are dropped
        alu_valid = 1'b1; alu_num = 5'd0; alu_data = 32'hDEAD;
        lsu_valid = 1'b1; lsu_num = 5'd0; lsu_data = 32'hBEEF;
        #1;
        chk("t5_r0_ready", 32'(lsu_ready), 32'd1);
        step();
        alu_valid = 1'b0; lsu_valid = 1'b0;
        rs_num = 5'd0;
        #1;
        chk("t5_r0_we", 32'(rd_we), 32'd0);
        chk("t5_r0_pending", pending_mask, 32'd0);
        chk("t5_r0_drained", 32'(drained), 32'd1);
        chk("t5_r0_fwd_valid", 32'(rs_fwd_valid), 32'd0);
        alu_valid = 1'b1; alu_num = 5'd12; alu_data = 32'hC0;
        lsu_valid = 1'b1; lsu_num = 5'd13; lsu_data = 32'hD0;
        exp_wr(5'd12, 32'hC0);
        exp_wr(5'd13, 32'hD0);
        step();
        alu_num = 5'd0; alu_data = 32'h123;
        lsu_valid = 1'b0;
        step();
        alu_valid = 1'b0;
        chk("t5_pop_under_r0_we", 32'(rd_we), 32'd1);
        chk("t5_pop_under_r0_num", 32'(rd_num), 32'd13);
        chk("t5_pending_bit0", 32'(pending_mask[0]), 32'd0);
        step();

        // Reset mid-stream discards three buffered writes
        for (int k = 0; k < 3; k++) begin
            alu_valid = 1'b1; alu_num = 5'(14 + k); alu_data = 32'hE0 + 32'(k);
            lsu_valid = 1'b1; lsu_num = 5'(k + 1);  lsu_data = 32'h100 + 32'(k);
            exp_wr(5'(14 + k), 32'hE0 + 32'(k));
            step();
        end
        alu_valid = 1'b0; lsu_valid = 1'b0;
        #1;
        chk("t6_pending_pre", pending_mask, 32'h0001_000E);
        #1;
        rst_b = 1'b0;
        sb.delete();
        #1;
        chk("t6_rst_we", 32'(rd_we), 32'd0);
        chk("t6_rst_num", 32'(rd_num), 32'd0);
        chk("t6_rst_pending", pending_mask, 32'd0);
        chk("t6_rst_drained", 32'(drained), 32'd1);
        chk("t6_rst_ready", 32'(lsu_ready), 32'd1);
        step();
        step();
        rst_b = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("t6_no_stale_we", 32'(rd_we), 32'd0);
            chk("t6_drained", 32'(drained), 32'd1);
        end

        n = 0;
        while (drained !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        chk("final_drain_in_time", 32'(drained), 32'd1);
        chk("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
